// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : display_scan_ctrl
//  Purpose  : Frame-synchronous value/mode holder and 3-digit 7-segment scanner
//             with debounced octal/hex mode button.
//  Revision : 1.0
// ============================================================================

module display_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16,
    parameter int DEB_CYC   = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] BIN_in,
    input  logic       load,
    input  logic       mode_btn,
    input  logic [2:0] A,
    input  logic [2:0] B,
    input  logic [2:0] C,
    input  logic [2:0] D,
    input  logic [2:0] E,
    input  logic [2:0] F,
    input  logic [2:0] G,
    output logic [7:0] BIN,
    output logic       sel,
    output logic [6:0] SEG,
    output logic [2:0] DIG_N,
    output logic       frame
);

    localparam int c_SLOT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int c_SLOT_W   = (c_SLOT_MAX > 1) ? $clog2(c_SLOT_MAX) : 1;
    localparam int c_DEB_W    = $clog2(DEB_CYC);

    localparam logic [c_SLOT_W-1:0] c_SHOW_LAST  = c_SLOT_W'(SCAN_DIV - 1);
    localparam logic [c_SLOT_W-1:0] c_BLANK_LAST = c_SLOT_W'(BLANK_CYC - 1);
    localparam logic [c_SLOT_W-1:0] c_SLOT_ONE   = c_SLOT_W'(1);
    localparam logic [c_DEB_W-1:0]  c_DEB_LAST   = c_DEB_W'(DEB_CYC - 1);
    localparam logic [c_DEB_W-1:0]  c_DEB_ONE    = c_DEB_W'(1);
    localparam logic [1:0]          c_LAST_DIG   = 2'd2;

    typedef enum logic [0:0] {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_SLOT_W-1:0] r_slot_cnt;
    logic [c_SLOT_W-1:0] w_slot_cnt_nxt;
    logic [1:0]          r_idx;
    logic [1:0]          w_idx_nxt;
    logic                w_boundary;

    logic [7:0]          r_pend;
    logic [7:0]          r_bin;
    logic                r_sel;
    logic                r_toggle_pend;

    logic                r_sync1;
    logic                r_sync2;
    logic                r_btn_stable;
    logic [c_DEB_W-1:0]  r_deb_cnt;
    logic                w_deb_done;
    logic                w_press;

    logic [6:0]          r_seg;
    logic [2:0]          r_dig_n;
    logic [6:0]          w_seg;
    logic [2:0]          w_dig_n;

    // ------------------------------------------------------------------
    // Scan sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_BLANK;
            r_slot_cnt <= '0;
            r_idx      <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_slot_cnt <= w_slot_cnt_nxt;
            r_idx      <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_slot_cnt_nxt = r_slot_cnt + c_SLOT_ONE;
        w_idx_nxt      = r_idx;
        w_boundary     = 1'b0;
        case (r_state)
            S_BLANK: begin
                if (r_slot_cnt == c_BLANK_LAST) begin
                    w_state_nxt    = S_SHOW;
                    w_slot_cnt_nxt = '0;
                end
            end
            S_SHOW: begin
                if (r_slot_cnt == c_SHOW_LAST) begin
                    w_state_nxt    = S_BLANK;
                    w_slot_cnt_nxt = '0;
                    if (r_idx == c_LAST_DIG) begin
                        w_idx_nxt  = 2'd0;
                        w_boundary = 1'b1;
                    end else begin
                        w_idx_nxt  = r_idx + 2'd1;
                    end
                end
            end
            default: begin
                w_state_nxt    = S_BLANK;
                w_slot_cnt_nxt = '0;
                w_idx_nxt      = 2'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Mode button: two-flop synchroniser followed by level debounce
    // ------------------------------------------------------------------
    assign w_deb_done = (r_sync2 != r_btn_stable) && (r_deb_cnt == c_DEB_LAST);
    assign w_press    = w_deb_done && r_sync2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_btn_stable <= 1'b0;
            r_deb_cnt    <= '0;
        end else begin
            r_sync1 <= mode_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_btn_stable) begin
                r_deb_cnt <= '0;
            end else if (w_deb_done) begin
                r_btn_stable <= r_sync2;
                r_deb_cnt    <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + c_DEB_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Value/mode staging; both commit together at the frame boundary so a
    // frame never mixes two values or two modes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend        <= 8'h00;
            r_bin         <= 8'h00;
            r_sel         <= 1'b0;
            r_toggle_pend <= 1'b0;
        end else begin
            if (load) begin
                r_pend <= BIN_in;
            end
            if (w_boundary) begin
                r_bin         <= r_pend;
                r_sel         <= r_sel ^ r_toggle_pend;
                // A press landing on the boundary belongs to the next frame.
                r_toggle_pend <= w_press;
            end else if (w_press) begin
                r_toggle_pend <= ~r_toggle_pend;
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit drive; in hex mode digit 2 keeps its slot but stays dark
    // ------------------------------------------------------------------
    always_comb begin
        w_dig_n = 3'b111;
        w_seg   = 7'b0000000;
        if (r_state == S_SHOW) begin
            case (r_idx)
                2'd0: begin
                    w_dig_n = 3'b110;
                    w_seg   = {G[0], F[0], E[0], D[0], C[0], B[0], A[0]};
                end
                2'd1: begin
                    w_dig_n = 3'b101;
                    w_seg   = {G[1], F[1], E[1], D[1], C[1], B[1], A[1]};
                end
                2'd2: begin
                    if (!r_sel) begin
                        w_dig_n = 3'b011;
                        w_seg   = {G[2], F[2], E[2], D[2], C[2], B[2], A[2]};
                    end
                end
                default: begin
                    w_dig_n = 3'b111;
                    w_seg   = 7'b0000000;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg   <= 7'b0000000;
            r_dig_n <= 3'b111;
        end else begin
            r_seg   <= w_seg;
            r_dig_n <= w_dig_n;
        end
    end

    assign BIN   = r_bin;
    assign sel   = r_sel;
    assign SEG   = r_seg;
    assign DIG_N = r_dig_n;
    assign frame = w_boundary;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_display_scan_ctrl
//  Purpose  : Scoreboard bench for display_scan_ctrl (SCAN_DIV=4, BLANK_CYC=2,
//             DEB_CYC=3).
//  Revision : 1.0
// ============================================================================

module tb_display_scan_ctrl;

    localparam int SCAN_DIV  = 4;
    localparam int BLANK_CYC = 2;
    localparam int DEB_CYC   = 3;
    localparam int FRAME_LEN = 3 * (SCAN_DIV + BLANK_CYC);

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] BIN_in;
    logic       load;
    logic       mode_btn;
    logic [2:0] A, B, C, D, E, F, G;
    logic [7:0] BIN;
    logic       sel;
    logic [6:0] SEG;
    logic [2:0] DIG_N;
    logic       frame;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC),
        .DEB_CYC   (DEB_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .BIN_in   (BIN_in),
        .load     (load),
        .mode_btn (mode_btn),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .E        (E),
        .F        (F),
        .G        (G),
        .BIN      (BIN),
        .sel      (sel),
        .SEG      (SEG),
        .DIG_N    (DIG_N),
        .frame    (frame)
    );

    typedef struct {
        logic [2:0] dig;
        logic [6:0] seg;
        int         pre;    // expected dark cycles before this digit, 0 = unchecked
    } lit_t;

    typedef struct {
        logic [7:0] bin;
        logic       sel;
    } cmt_t;

    lit_t q_lit[$];
    cmt_t q_frame[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] b, input logic s);
        cmt_t c;
        c.bin = b;
        c.sel = s;
        q_frame.push_back(c);
    endtask

    // Lit digits expected in one frame window for the given committed mode.
    task automatic push_window(input logic s, input int pre0,
                               input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2);
        lit_t e;
        e.dig = 3'b110; e.seg = s0; e.pre = pre0; q_lit.push_back(e);
        e.dig = 3'b101; e.seg = s1; e.pre = 2;    q_lit.push_back(e);
        if (!s) begin
            e.dig = 3'b011; e.seg = s2; e.pre = 2; q_lit.push_back(e);
        end
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (frame !== 1'b1 && n < 2 * FRAME_LEN);
        if (frame !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL frame_timeout: no frame pulse within %0d cycles", n);
        end
    endtask

    task automatic wait_dig(input logic [2:0] d);
        int n;
        n = 0;
        while (DIG_N !== d && n < 2 * FRAME_LEN) begin
            step();
            n++;
        end
        if (DIG_N !== d) begin
            n_cmp++;
            n_fail++;
            $display("FAIL dig_timeout: DIG_N never reached %b", d);
        end
    endtask

    task automatic first_lit();
        int n;
        n = 0;
        while (DIG_N !== 3'b110 && n < 12) begin
            step();
            n++;
        end
        check(n == 3, "first_lit_delay", n, 3);
    endtask

    // Monitor: per-cycle invariants plus pops from both scoreboards.
    initial begin : monitor
        bit         rst_prev, in_run, pend, run_ok;
        int         cyc, last_frame, run_len, dark_len;
        logic [7:0] cur_bin;
        logic       cur_sel;
        lit_t       ex;
        cmt_t       c;
        rst_prev = 1'b1; in_run = 1'b0; pend = 1'b0; run_ok = 1'b0;
        cyc = 0; last_frame = -1; run_len = 0; dark_len = 0;
        cur_bin = 8'h00; cur_sel = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                if (!rst_prev)
                    check({BIN, sel, SEG, DIG_N, frame} === {8'h00, 1'b0, 7'h00, 3'b111, 1'b0},
                          "reset_state", {BIN, sel, SEG, DIG_N, frame},
                          {8'h00, 1'b0, 7'h00, 3'b111, 1'b0});
                in_run = 1'b0; pend = 1'b0; last_frame = -1; dark_len = 0;
                cur_bin = 8'h00; cur_sel = 1'b0;
            end else begin
                if (pend) begin
                    pend = 1'b0;
                    check(q_frame.size() != 0, "commit_unexpected", 0, 1);
                    if (q_frame.size() != 0) begin
                        c = q_frame.pop_front();
                        cur_bin = c.bin;
                        cur_sel = c.sel;
                    end
                end
                check({BIN, sel} === {cur_bin, cur_sel}, "bin_sel", {BIN, sel}, {cur_bin, cur_sel});
                if (frame === 1'b1) begin
                    if (last_frame >= 0)
                        check(cyc - last_frame == FRAME_LEN, "frame_period",
                              cyc - last_frame, FRAME_LEN);
                    last_frame = cyc;
                    pend = 1'b1;
                end
                if (DIG_N !== 3'b111) begin
                    if (!in_run) begin
                        check(q_lit.size() != 0, "lit_unexpected", {DIG_N, SEG}, 0);
                        if (q_lit.size() != 0) ex = q_lit[0];
                        else begin ex.dig = 3'b111; ex.seg = 7'h00; ex.pre = 0; end
                        if (ex.pre != 0)
                            check(dark_len == ex.pre, "dark_gap", dark_len, ex.pre);
                        in_run = 1'b1; run_len = 0; run_ok = 1'b1;
                    end
                    if (DIG_N !== ex.dig || SEG !== ex.seg) run_ok = 1'b0;
                    run_len++;
                end else begin
                    if (in_run) begin
                        if (q_lit.size() != 0) void'(q_lit.pop_front());
                        check(run_ok && run_len == SCAN_DIV, "lit_run",
                              {ex.dig, ex.seg, 8'(run_len)}, {ex.dig, ex.seg, 8'(SCAN_DIV)});
                        in_run = 1'b0;
                        dark_len = 0;
                    end
                    check(SEG === 7'h00, "dark_seg", SEG, 0);
                    dark_len++;
                end
            end
            rst_prev = rst_n;
        end
    end

    initial begin : stim
        rst_n = 1'b0; load = 1'b1; BIN_in = 8'hFF; mode_btn = 1'b0;
        A = 3'b001; B = 3'b000; C = 3'b000; D = 3'b000;
        E = 3'b000; F = 3'b000; G = 3'b000;
        repeat (3) step();

        // Reset release, scan order and first load
        q_lit.delete(); q_frame.delete();
        push_frame(8'hA5, 1'b0);
        push_window(1'b0, 0, 7'b0000001, 7'b0000000, 7'b0000000);
        rst_n = 1'b1; load = 1'b0;
        first_lit();
        BIN_in = 8'hA5; load = 1'b1; step(); load = 1'b0; BIN_in = 8'h00;
        wait_frame();                                               // p0

        // Two loads in one frame: last wins
        push_frame(8'h22, 1'b0);
        push_window(1'b0, 2, 7'b0000001, 7'b0000000, 7'b0000000);
        repeat (3) step();
        BIN_in = 8'h11; load = 1'b1; step(); load = 1'b0;
        repeat (3) step();
        BIN_in = 8'h22; load = 1'b1; step(); load = 1'b0;
        wait_frame();                                               // p1

        // Bouncy press: exactly one toggle
        push_frame(8'h22, 1'b1);
        push_window(1'b0, 2, 7'b0000001, 7'b0000000, 7'b0000000);
        repeat (2) step();
        mode_btn = 1'b1; step(); mode_btn = 1'b0; step(); mode_btn = 1'b1;
        wait_frame();                                               // p2

        // Hex frame: digit 2 dark, release is not a press
        push_frame(8'h22, 1'b1);
        push_window(1'b1, 2, 7'b0000001, 7'b0000000, 7'b0000000);
        mode_btn = 1'b0;
        wait_frame();                                               // p3

        // Two clean presses inside one frame cancel
        push_frame(8'h22, 1'b1);
        push_window(1'b1, 8, 7'b0000001, 7'b0000000, 7'b0000000);
        mode_btn = 1'b1; repeat (5) step();
        mode_btn = 1'b0; repeat (5) step();
        mode_btn = 1'b1; repeat (5) step();
        mode_btn = 1'b0;
        wait_frame();                                               // p4

        // New segment pattern; press timed to land on the boundary edge
        B = 3'b010; G = 3'b110;
        push_frame(8'h22, 1'b1);
        push_window(1'b1, 8, 7'b0000001, 7'b1000010, 7'b0000000);
        repeat (14) step();
        mode_btn = 1'b1;
        wait_frame();                                               // p5

        // Boundary press flips one frame later; boundary load commits next frame
        push_frame(8'h3C, 1'b0);
        push_window(1'b1, 8, 7'b0000001, 7'b1000010, 7'b0000000);
        BIN_in = 8'h3C; load = 1'b1; step(); load = 1'b0;
        repeat (4) step();
        mode_btn = 1'b0;
        wait_frame();                                               // p6

        // Reset during digit 1 with a pending load
        push_window(1'b0, 8, 7'b0000001, 7'b1000010, 7'b1000000);
        repeat (2) step();
        BIN_in = 8'h77; load = 1'b1; step(); load = 1'b0;
        wait_dig(3'b101);
        step();
        rst_n = 1'b0;
        repeat (2) step();
        q_lit.delete(); q_frame.delete();
        push_frame(8'h00, 1'b0);
        push_window(1'b0, 0, 7'b0000001, 7'b1000010, 7'b1000000);
        rst_n = 1'b1;
        first_lit();
        wait_frame();
        repeat (3) step();
        check(q_frame.size() == 0, "frame_queue_drained", q_frame.size(), 0);
        check(q_lit.size() == 0, "lit_queue_drained", q_lit.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
